// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel streaming path.
package sobel_pkg;

   localparam int PIX_W          = 8;
   localparam int WIN_TAPS       = 9;
   localparam int WIN_W          = PIX_W * WIN_TAPS;
   localparam int DEF_IMG_WIDTH  = 720;
   localparam int DEF_IMG_HEIGHT = 540;

   // Output FIFO entry: end-of-frame marker plus gradient magnitude.
   typedef struct packed {
      logic             last;
      logic [PIX_W-1:0] data;
   } fifo_entry_t;

   // Window byte index: r=0 oldest line, c=0 newest column.
   function automatic int win_idx(input int r, input int c);
      return r * 3 + c;
   endfunction

endpackage

// File: rtl/sobel_out_fifo.sv
// Small synchronous FIFO holding tagged Sobel results.
module sobel_out_fifo
   import sobel_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  fifo_entry_t      push_data,
   input  logic             pop,
   output fifo_entry_t      head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fifo_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head reads as zero when empty so the output bus is quiet out of reset.
   assign head    = empty ? '0 : mem[rd_ptr];

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Entry storage, not reset: validity is tracked by count.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy; simultaneous push and pop keep count steady.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop)  rd_ptr <= nxt(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-scan controller: line buffers, 3x3 window, result tagging and
// credit-based output buffering around the sobel_op datapath.
module sobel_window_ctrl
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_data,
   output logic [WIN_W-1:0] win_data,
   input  logic [PIX_W-1:0] op_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_data,
   output logic             out_last
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CR_W  = CNT_W + 2;

   logic [COL_W-1:0]           col;
   logic [ROW_W-1:0]           row;
   logic [PIX_W-1:0]           lb1 [IMG_WIDTH];
   logic [PIX_W-1:0]           lb2 [IMG_WIDTH];
   logic [PIX_W-1:0]           lb1_rd;
   logic [PIX_W-1:0]           lb2_rd;
   logic [2:0][2:0][PIX_W-1:0] win;
   logic [2:1]                 vld_pipe;
   logic [2:1]                 lst_pipe;
   logic                       accept;
   logic                       interior;
   logic                       col_end;
   logic                       row_end;
   logic                       frame_end;
   logic [CNT_W-1:0]           fifo_count;
   logic [CR_W-1:0]            credit;
   fifo_entry_t                fifo_push;
   fifo_entry_t                fifo_head;

   assign accept    = in_valid && in_ready;
   assign col_end   = (col == COL_W'(IMG_WIDTH - 1));
   assign row_end   = (row == ROW_W'(IMG_HEIGHT - 1));
   assign frame_end = row_end && col_end;
   assign interior  = (row >= ROW_W'(2)) && (col >= COL_W'(2));
   assign lb1_rd    = lb1[col];
   assign lb2_rd    = lb2[col];

   // Results already committed (in FIFO or in flight through sobel_op)
   // must fit, so the FIFO can never overflow.
   assign credit   = CR_W'(fifo_count) + CR_W'(vld_pipe[1]) + CR_W'(vld_pipe[2]);
   assign in_ready = !reset && (credit < CR_W'(FIFO_DEPTH));

   // Raster position of the pixel being accepted; wraps straight into the next frame.
   always_ff @(posedge clock) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Line buffers age one line per pass; contents are don't-care after reset.
   always_ff @(posedge clock) begin
      if (accept) begin
         lb2[col] <= lb1_rd;
         lb1[col] <= in_data;
      end
   end

   // Window shifts toward older columns; column 0 loads the current column.
   always_ff @(posedge clock) begin
      if (reset) begin
         win <= '0;
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win[r][2] <= win[r][1];
            win[r][1] <= win[r][0];
         end
         win[0][0] <= lb2_rd;
         win[1][0] <= lb1_rd;
         win[2][0] <= in_data;
      end
   end

   for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar c = 0; c < 3; c++) begin : g_col
         assign win_data[win_idx(r, c)*PIX_W +: PIX_W] = win[r][c];
      end
   end

   // Tags follow sobel_op's one-cycle latency; stage 2 lines up with op_result.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_pipe <= '0;
         lst_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1], accept && interior};
         lst_pipe <= {lst_pipe[1], accept && frame_end};
      end
   end

   assign fifo_push.last = lst_pipe[2];
   assign fifo_push.data = op_result;

   sobel_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (vld_pipe[2]),
      .push_data (fifo_push),
      .pop       (out_valid && out_ready),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign out_valid = (fifo_count != '0);
   assign out_data  = fifo_head.data;
   assign out_last  = fifo_head.last;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl with a behavioural sobel_op beside it.
module tb_sobel_window_ctrl;
   import sobel_pkg::*;

   localparam int W = 8;
   localparam int H = 4;
   localparam int D = 4;
   localparam int PER_FRAME = (W - 2) * (H - 2);

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic [71:0] win_data;
   logic [7:0]  op_result;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        out_last;

   typedef struct {
      logic       last;
      logic [7:0] data;
      int         cyc;
      bit         lat;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] img [H][W];
   int errors = 0, checks = 0;
   int cyc = 0, n_acc = 0, n_rcv = 0, n_push = 0;
   int rdy_mode = 1, gap_pct = 0;
   bit lat_on = 0, chk22 = 0, frm_done = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .win_data(win_data), .op_result(op_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last)
   );

   function automatic int sp(input logic [7:0] b);
      return int'($signed(b));
   endfunction

   function automatic int absi(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Stand-in for sobel_op: registered magnitude of the presented window.
   function automatic logic [7:0] op_mag(input logic [71:0] w);
      int p [3][3];
      int gx, gy, m;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            p[r][c] = sp(w[(r*3+c)*8 +: 8]);
      gx = (p[0][0] + 2*p[1][0] + p[2][0]) - (p[0][2] + 2*p[1][2] + p[2][2]);
      gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
      m  = (absi(gx) + absi(gy)) / 2;
      return (m > 255) ? 8'd255 : 8'(m);
   endfunction

   always @(posedge clock) op_result <= op_mag(win_data);

   // Reference: Sobel magnitude of image pixel (y,x) straight from the frame.
   function automatic logic [7:0] ref_mag(input int y, input int x);
      int gx = 0, gy = 0, m, wt;
      for (int d = -1; d <= 1; d++) begin
         wt = (d == 0) ? 2 : 1;
         gx += wt * (sp(img[y+d][x+1]) - sp(img[y+d][x-1]));
         gy += wt * (sp(img[y+1][x+d]) - sp(img[y-1][x+d]));
      end
      m = (absi(gx) + absi(gy)) / 2;
      return (m > 255) ? 8'd255 : 8'(m);
   endfunction

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fill_img(input int mode);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            case (mode)
               0:       img[y][x] = 8'd10;
               1:       img[y][x] = ((x % 4) >= 2) ? 8'd100 : 8'd0;
               2:       img[y][x] = 8'(y*16 + x);
               3:       img[y][x] = 8'($urandom_range(127));
               default: img[y][x] = 8'($urandom_range(255));
            endcase
   endtask

   // Drive one pixel; entered and left just after a rising edge.
   task automatic send_px(input int y, input int x);
      int waited = 0;
      logic [71:0] ew;
      exp_t e;
      in_valid = 1'b1;
      in_data  = img[y][x];
      @(negedge clock);
      while (!in_ready) begin
         waited++;
         if (waited > 2000) begin
            $display("FAIL in_ready timeout: got 0 expected 1 at pixel (%0d,%0d)", y, x);
            $fatal(1, "stuck");
         end
         @(negedge clock);
      end
      @(posedge clock); #1;
      n_acc++;
      in_valid = 1'b0;
      if (y >= 2 && x >= 2) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               ew[(r*3+c)*8 +: 8] = img[y-2+r][x-c];
         chk("window", win_data, ew);
         if (chk22 && y == 2 && x == 2)
            chk("win_rc22", win_data, 72'h20_21_22_10_11_12_00_01_02);
         e.last = (y == H-1) && (x == W-1);
         e.data = ref_mag(y-1, x-1);
         e.cyc  = cyc;
         e.lat  = lat_on;
         sbq.push_back(e);
         n_push++;
      end
      while ($urandom_range(99) < gap_pct) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic send_frame();
      frm_done = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            send_px(y, x);
      frm_done = 1;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sbq.size() != 0 && t < 1000) begin
         @(posedge clock);
         t++;
      end
      chk("drain queue", sbq.size(), 0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("idle out_valid", out_valid, 0);
      @(posedge clock); #1;
   endtask

   // Sink handshake driver.
   initial forever begin
      @(posedge clock); #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(1));
      endcase
   end

   // Monitor: pop the scoreboard on every output handshake.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("spurious out_valid", out_valid, 0);
            end else begin
               e = sbq.pop_front();
               chk("out_data", out_data, e.data);
               chk("out_last", out_last, e.last);
               if (e.lat) chk("latency", cyc - e.cyc, 2);
               n_rcv++;
            end
         end
      end
   end

   initial begin
      int rcv0, exp_acc, cnt, t;
      bit found;

      // Reset state
      @(negedge clock);
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_last", out_last, 0);
      chk("rst win_data", win_data, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("post-rst in_ready", in_ready, 1);
      @(posedge clock); #1;

      // Directed frames at full throughput with latency tracking
      rdy_mode = 1; gap_pct = 0; lat_on = 1;
      fill_img(0); send_frame();
      fill_img(1); send_frame();
      chk22 = 1; fill_img(2); send_frame(); chk22 = 0;
      wait_drain();
      lat_on = 0;

      // Random pixels, gaps and back-pressure, full byte range
      rdy_mode = 2; gap_pct = 30;
      fill_img(4); send_frame();
      fill_img(3); send_frame();
      rdy_mode = 1;
      wait_drain();

      // Stall: sink blocked from the start
      gap_pct = 0; rdy_mode = 0;
      @(posedge clock); #1;
      cnt = 0; found = 0; exp_acc = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if (!found && y >= 2 && x >= 2) begin
               cnt++;
               if (cnt == D) begin
                  exp_acc = y*W + x + 1;
                  found = 1;
               end
            end
      n_acc = 0; frm_done = 0;
      fill_img(3);
      fork send_frame(); join_none
      repeat (60) @(posedge clock);
      #1;
      chk("stall in_ready", in_ready, 0);
      chk("stall accepts", n_acc, exp_acc);
      chk("stall out_valid", out_valid, 1);
      rdy_mode = 1;
      t = 0;
      while (!frm_done && t < 3000) begin
         @(posedge clock); #1;
         t++;
      end
      chk("stall frame done", frm_done, 1);
      rcv0 = n_rcv - (exp_acc > 0 ? 0 : 0);
      wait_drain();

      // Reset in the middle of row 2
      rdy_mode = 1; gap_pct = 0;
      fill_img(3);
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < W; x++)
            send_px(y, x);
      for (int x = 0; x < 5; x++) send_px(2, x);
      reset = 1'b1;
      @(negedge clock);
      chk("mid-rst in_ready", in_ready, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      n_push -= sbq.size();
      sbq.delete();
      @(negedge clock);
      chk("mid-rst out_valid", out_valid, 0);
      chk("mid-rst out_last", out_last, 0);
      chk("mid-rst win_data", win_data, 0);
      @(posedge clock); #1;
      rcv0 = n_rcv;
      fill_img(3); send_frame();
      wait_drain();
      chk("post-rst frame count", n_rcv - rcv0, PER_FRAME);

      // Two back-to-back frames with random sink readiness
      rdy_mode = 2; gap_pct = 0;
      rcv0 = n_rcv;
      fill_img(3); send_frame();
      fill_img(4); send_frame();
      rdy_mode = 1;
      wait_drain();
      chk("b2b count", n_rcv - rcv0, 2*PER_FRAME);

      chk("total results", n_rcv, n_push);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Streaming controller that sequences the `sobel_op` 3x3 gradient datapath over raster-order frames. It accepts one 8-bit pixel per handshake and maintains two line buffers plus a 3x3 window register. It presents the 72-bit window to `sobel_op`, tags its one-cycle result latency, and emits interior-pixel results through a small output FIFO with valid/ready back-pressure and an end-of-frame marker. It sits between the pixel source and the magnitude output stream in the sobel top level.

## Interface
- `IMG_WIDTH`, default 720: pixels per line, ≥3.
- `IMG_HEIGHT`, default 540: lines per frame, ≥3.
- `FIFO_DEPTH`, default 4: output FIFO entries. A value ≥4 is required for full throughput.

- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: source pixel valid.
- `in_ready` out 1: controller accepts the pixel this cycle.
- `in_data` in 8: pixel, raster order, row-major.
- `win_data` out 72: window to `sobel_op.in`.
- `op_result` in 8: `sobel_op.out`, registered result of the window present one edge earlier.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: sink accepts.
- `out_data` out 8: gradient magnitude.
- `out_last` out 1: marks the final result of the frame.

## Operation
- An accept occurs when `in_valid && in_ready`. Only accepts advance state.
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) hold the position of the pixel being accepted.
  - `col` wraps to 0 and increments `row` after IMG_WIDTH-1.
  - `row` wraps to 0 after the last pixel, so the next frame starts immediately.
- Line buffers `lb1` (row-1) and `lb2` (row-2) are IMG_WIDTH x 8 with asynchronous read at `col`. On accept: `lb2[col] <= lb1[col]`, `lb1[col] <= in_data`.
- Window byte k = `win_data[k*8 +: 8]`, with k = r*3 + c.
  - r=0 is the oldest line and r=2 is the current line.
  - c=0 is the newest column.
- Window shift on accept:
  - column 2 <= column 1, column 1 <= column 0.
  - Column 0 <= {r0: `lb2[col]`, r1: `lb1[col]`, r2: `in_data`}.
- An accept is interior when `row>=2 && col>=2`. The result is the pixel centred at (row-1, col-1). Border pixels produce no output: (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame.
- Tag pipeline:
  - `s1_valid <= accept && interior` and `s1_last <= accept && row==IMG_HEIGHT-1 && col==IMG_WIDTH-1`.
  - `s2 <= s1` every cycle.
  - When `s2_valid`, push `{s2_last, op_result}` into the FIFO.
- Credit rule: `in_ready = !reset && (fifo_count + s1_valid + s2_valid) < FIFO_DEPTH`. The FIFO therefore never overflows, and the window may change freely because `sobel_op` re-registers every cycle.
- Pixel bytes pass through raw. `sobel_op` treats them as signed, so sources keep values ≤127 or accept wrap semantics.
- FIFO pops on `out_valid && out_ready`. A push and a pop in the same cycle leave the count unchanged.

## Timing
- Reset values:
  - `in_ready`=0 while `reset` is high, then 1.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `win_data`=0.
  - Counters=0, `s1`/`s2`=0, FIFO empty.
- Line-buffer contents are not reset. They are don't-care because rows 0-1 never produce output.
- Latency: an interior accept at edge T updates the window at T. `op_result` is valid after T+1, the push happens at T+2, and `out_valid` is high in the cycle after T+2. Minimum latency is 2 clocks.
- Throughput is one result per clock with `out_ready` held at 1.
- Stall: with `out_ready`=0, at most FIFO_DEPTH results are buffered. `in_ready` falls once the credit sum reaches the limit, and no result is lost or reordered.
- Reset mid-frame: all in-flight tags and FIFO contents are discarded. The next accepted pixel is (0,0).

## Structure
- Shared package `sobel_pkg`: `PIX_W`=8, `WIN_W`=72, `WIN_TAPS`=9, the window index constant (r*3+c), and default image dimensions.
- Sub-module `sobel_out_fifo`: synchronous FIFO, 9-bit entries, parameter depth, count output.
- `sobel_op` is instantiated beside this block in the top level, wired `win_data`→`in` and `out`→`op_result`.

## Test plan
- IMG 4x4, constant 10, `out_ready`=1 -> exactly 4 results, all 0, with `out_last` only on the 4th; output 2 clocks after accepts (2,2),(2,3),(3,2),(3,3).
- IMG 4x4, every line {0,0,100,100} -> 4 results, each 200 (|Gx|=400, Gy=0, halved).
- Pixel = row*16+col on 4x4 -> at accept (2,2), `win_data` bytes k0..k8 = 0x02,0x01,0x00,0x12,0x11,0x10,0x22,0x21,0x20.
- IMG 8x4, `out_ready`=0 from the start -> `in_ready` drops with fifo_count+s1+s2=4 and no FIFO overflow. Release `out_ready` -> all 12 results arrive in order, values match the model.
- `reset` asserted for 1 cycle mid-row 2 -> `out_valid` low the next cycle. A new full frame then yields a correct result count and values.
- Two back-to-back 4x4 frames, random `out_ready` -> 8 results with `out_last` on the 4th and 8th; counters wrap with no gap.
